// File: rtl/sequenciador_ula.sv
// sequenciador_ula: runs one ULA operation per rising edge of executar and owns the memory/display registers.
// Defining HISTORICO_EN adds a 4-entry history of non-null results.
module sequenciador_ula #(
    parameter int unsigned LARGURA      = 8,
    parameter int unsigned LATENCIA_ULA = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               executar,
    input  logic               limpar,
    input  logic [2:0]         operacao_in,
    input  logic [LARGURA-1:0] operando_a_in,
    input  logic [LARGURA-1:0] operando_b_in,
    input  logic               usar_memoria,
    input  logic [LARGURA-1:0] resultado_ula,
    output logic [2:0]         ula_operacao,
    output logic [LARGURA-1:0] ula_a,
    output logic [LARGURA-1:0] ula_b,
    output logic               carregar_memoria,
    output logic [LARGURA-1:0] valor_memoria,
    output logic [LARGURA-1:0] resultado_final,
    output logic               ocupado,
`ifdef HISTORICO_EN
    input  logic [1:0]         historico_sel,
    output logic [LARGURA-1:0] historico_valor,
`endif
    output logic               pronto
);

    localparam logic [1:0] ESPERA  = 2'd0;
    localparam logic [1:0] CAPTURA = 2'd1;
    localparam logic [1:0] CALCULA = 2'd2;
    localparam logic [1:0] GRAVA   = 2'd3;

    localparam logic [3:0] ULTIMO_CICLO = 4'(LATENCIA_ULA);

    logic [1:0] estado;
    logic [3:0] contador;
    logic       executar_q;
    logic       inicio;

    assign inicio           = executar & ~executar_q;
    assign ocupado          = (estado != ESPERA);
    assign carregar_memoria = (estado == GRAVA) && (ula_operacao != 3'b000);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            estado          <= ESPERA;
            contador        <= '0;
            executar_q      <= 1'b0;
            ula_operacao    <= '0;
            ula_a           <= '0;
            ula_b           <= '0;
            valor_memoria   <= '0;
            resultado_final <= '0;
            pronto          <= 1'b0;
        end else begin
            executar_q <= executar;
            pronto     <= 1'b0;
            case (estado)
                ESPERA: begin
                    // clear has priority and swallows a coincident start edge
                    if (limpar) begin
                        valor_memoria <= '0;
                    end else if (inicio) begin
                        estado <= CAPTURA;
                    end
                end
                CAPTURA: begin
                    ula_operacao <= operacao_in;
                    ula_b        <= operando_b_in;
                    ula_a        <= usar_memoria ? valor_memoria : operando_a_in;
                    contador     <= '0;
                    estado       <= CALCULA;
                end
                CALCULA: begin
                    if (contador == ULTIMO_CICLO) begin
                        estado <= GRAVA;
                    end else begin
                        contador <= contador + 4'd1;
                    end
                end
                GRAVA: begin
                    resultado_final <= resultado_ula;
                    if (ula_operacao != 3'b000) begin
                        valor_memoria <= resultado_ula;
                    end
                    pronto <= 1'b1;
                    estado <= ESPERA;
                end
                default: estado <= ESPERA;
            endcase
        end
    end

`ifdef HISTORICO_EN
    logic [LARGURA-1:0] historico [4];
    logic [1:0]         ponteiro;
    logic [1:0]         indice_leitura;

    // ponteiro addresses the next slot, so the newest entry sits one behind it
    assign indice_leitura  = ponteiro - 2'd1 - historico_sel;
    assign historico_valor = historico[indice_leitura];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ponteiro <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                historico[i] <= '0;
            end
        end else if ((estado == ESPERA) && limpar) begin
            ponteiro <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                historico[i] <= '0;
            end
        end else if ((estado == GRAVA) && (ula_operacao != 3'b000)) begin
            historico[ponteiro] <= resultado_ula;
            ponteiro            <= ponteiro + 2'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sequenciador_ula.sv
// Self-checking bench for sequenciador_ula: timeline reference model, per-cycle compare, directed literal checks.
// Define HISTORICO_EN to also exercise the history buffer.
module tb_sequenciador_ula;

    localparam int LAT = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       executar = 1'b0;
    logic       limpar = 1'b0;
    logic [2:0] operacao_in = '0;
    logic [7:0] operando_a_in = '0;
    logic [7:0] operando_b_in = '0;
    logic       usar_memoria = 1'b0;
    logic [7:0] resultado_ula;
    logic [2:0] ula_operacao;
    logic [7:0] ula_a, ula_b;
    logic       carregar_memoria;
    logic [7:0] valor_memoria, resultado_final;
    logic       ocupado, pronto;
`ifdef HISTORICO_EN
    logic [1:0] historico_sel = '0;
    logic [7:0] historico_valor;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sequenciador_ula #(.LARGURA(8), .LATENCIA_ULA(LAT)) dut (
        .clk(clk), .rst(rst), .executar(executar), .limpar(limpar),
        .operacao_in(operacao_in), .operando_a_in(operando_a_in), .operando_b_in(operando_b_in),
        .usar_memoria(usar_memoria), .resultado_ula(resultado_ula),
        .ula_operacao(ula_operacao), .ula_a(ula_a), .ula_b(ula_b),
        .carregar_memoria(carregar_memoria), .valor_memoria(valor_memoria),
        .resultado_final(resultado_final), .ocupado(ocupado),
`ifdef HISTORICO_EN
        .historico_sel(historico_sel), .historico_valor(historico_valor),
`endif
        .pronto(pronto)
    );

    function automatic logic [7:0] ula_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0: ula_fn = b;
            3'd1: ula_fn = a + b;
            3'd2: ula_fn = a - b;
            3'd3: ula_fn = a & b;
            3'd4: ula_fn = a | b;
            3'd5: ula_fn = a ^ b;
            3'd6: ula_fn = a << 1;
            default: ula_fn = ~a;
        endcase
    endfunction

    // ULA stand-in: result appears LAT cycles after its inputs
    logic [7:0] pipe1 = '0, pipe2 = '0;
    always @(posedge clk) begin
        pipe1 <= ula_fn(ula_operacao, ula_a, ula_b);
        pipe2 <= pipe1;
    end
    assign resultado_ula = pipe2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            if (errors <= 30) $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Reference model: an operation started at edge k captures at k+1, strobes at k+LAT+2, completes at k+LAT+3.
    int unsigned ecount;
    bit          m_act;
    int unsigned m_k;
    logic [2:0]  m_op;
    logic [7:0]  m_a, m_b;
    logic        m_exec_prev;
    logic        e_ocupado = 0, e_pronto = 0, e_carregar = 0;
    logic [7:0]  e_mem = 0, e_res = 0, e_a = 0, e_b = 0;
    logic [2:0]  e_op = 0;
    logic [7:0]  m_hist [4];
    int unsigned m_wp;
    logic [7:0]  r;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ecount = 0; m_act = 0; m_exec_prev = 0;
            e_ocupado = 0; e_pronto = 0; e_carregar = 0;
            e_mem = 0; e_res = 0; e_a = 0; e_b = 0; e_op = 0;
            for (int i = 0; i < 4; i++) m_hist[i] = 0;
            m_wp = 0;
        end else begin
            ecount++;
            e_pronto = 0;
            e_carregar = 0;
            if (m_act) begin
                if (ecount == m_k + 1) begin
                    m_op = operacao_in;
                    m_b = operando_b_in;
                    m_a = usar_memoria ? e_mem : operando_a_in;
                    e_op = m_op; e_a = m_a; e_b = m_b;
                end
                if (ecount == m_k + LAT + 2 && m_op != 0) e_carregar = 1;
                if (ecount == m_k + LAT + 3) begin
                    r = ula_fn(m_op, m_a, m_b);
                    e_res = r;
                    if (m_op != 0) begin
                        e_mem = r;
                        m_hist[m_wp] = r;
                        m_wp = (m_wp + 1) % 4;
                    end
                    e_pronto = 1;
                    m_act = 0;
                end
            end else begin
                if (limpar) begin
                    e_mem = 0;
                    for (int i = 0; i < 4; i++) m_hist[i] = 0;
                    m_wp = 0;
                end else if (executar && !m_exec_prev) begin
                    m_act = 1;
                    m_k = ecount;
                end
            end
            m_exec_prev = executar;
            e_ocupado = m_act;
        end
    end

    always @(negedge clk) begin
        chk("ocupado", ocupado, e_ocupado);
        chk("pronto", pronto, e_pronto);
        chk("carregar_memoria", carregar_memoria, e_carregar);
        chk("valor_memoria", valor_memoria, e_mem);
        chk("resultado_final", resultado_final, e_res);
        chk("ula_operacao", ula_operacao, e_op);
        chk("ula_a", ula_a, e_a);
        chk("ula_b", ula_b, e_b);
`ifdef HISTORICO_EN
        chk("historico_valor", historico_valor, m_hist[(m_wp + 3 - historico_sel) % 4]);
`endif
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic um,
                         output int lat, output int loads);
        operacao_in = op; operando_a_in = a; operando_b_in = b; usar_memoria = um; executar = 1;
        lat = -1; loads = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (carregar_memoria) loads++;
            if (pronto) begin
                lat = i;
                break;
            end
            #1;
            executar = 0;
        end
        #1;
        executar = 0;
    endtask

    int lat, loads, np, nc, nb;

    initial begin
        repeat (2) tick();
        chk("reset_ocupado", ocupado, 0);
        chk("reset_memoria", valor_memoria, 0);
        rst = 1;
        tick();

        do_op(3'd1, 8'h12, 8'h05, 1'b0, lat, loads);
        chk("basic_latency", lat, 5);
        chk("basic_loads", loads, 1);
        chk("basic_memoria", valor_memoria, 8'h17);
        chk("basic_resultado", resultado_final, 8'h17);

        do_op(3'd1, 8'hFF, 8'h00, 1'b1, lat, loads);
        chk("chain_ula_a", ula_a, 8'h17);
        chk("chain_resultado", resultado_final, 8'h17);

        do_op(3'd0, 8'h33, 8'h09, 1'b0, lat, loads);
        chk("null_resultado", resultado_final, 8'h09);
        chk("null_loads", loads, 0);
        chk("null_memoria", valor_memoria, 8'h17);

        operacao_in = 3'd2; operando_a_in = 8'h40; operando_b_in = 8'h01; usar_memoria = 0; executar = 1;
        np = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (pronto) np++;
            #1;
            executar = (i == 2);
        end
        chk("drop_pronto_count", np, 1);
        chk("drop_memoria", valor_memoria, 8'h3F);

        operacao_in = 3'd1; operando_a_in = 8'h01; operando_b_in = 8'h01; executar = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            executar = 0;
        end
        chk("pre_reset_ocupado", ocupado, 1);
        rst = 0;
        #1;
        chk("reset_mid_ocupado", ocupado, 0);
        chk("reset_mid_memoria", valor_memoria, 0);
        chk("reset_mid_resultado", resultado_final, 0);
        tick();
        rst = 1;
        np = 0; nc = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (pronto) np++;
            if (carregar_memoria) nc++;
            #1;
        end
        chk("reset_no_pronto", np, 0);
        chk("reset_no_load", nc, 0);

        do_op(3'd1, 8'h20, 8'h01, 1'b0, lat, loads);
        chk("refill_memoria", valor_memoria, 8'h21);
        limpar = 1; executar = 1;
        tick();
        limpar = 0; executar = 0;
        nb = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ocupado) nb++;
            #1;
        end
        chk("clear_no_start", nb, 0);
        chk("clear_memoria", valor_memoria, 0);

`ifdef HISTORICO_EN
        for (int v = 1; v <= 5; v++) begin
            do_op(3'd1, 8'h00, 8'(v), 1'b0, lat, loads);
            tick();
        end
        for (int s = 0; s < 4; s++) begin
            historico_sel = 2'(s);
            #1;
            chk("hist_sel", historico_valor, 5 - s);
        end
`endif

        for (int c = 0; c < 3000; c++) begin
            tick();
            if ($urandom_range(0, 599) == 0) rst = 0;
            else rst = 1;
            executar = ($urandom_range(0, 2) == 0);
            limpar = ($urandom_range(0, 15) == 0);
            operacao_in = 3'($urandom_range(0, 7));
            operando_a_in = 8'($urandom);
            operando_b_in = 8'($urandom);
            usar_memoria = 1'($urandom);
`ifdef HISTORICO_EN
            historico_sel = 2'($urandom);
`endif
        end
        rst = 1;
        repeat (10) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
